mandel_frame_sequencer: RTL and testbench
=========================================

Name: mandel_frame_sequencer

Overview:
- Scans an H_RES x V_RES pixel grid in raster order.
- For each pixel it generates the complex constant c, drives one start of the single Mandelbrot iteration engine, waits for the engine's result, and presents the result on a ready/valid pixel stream toward the framebuffer/colour-gradient stage.
- Owns the engine: nothing else may drive the engine's start or c inputs.

Parameters:
- FIXED_POINT_WIDTH, 16, width of c values; same signed fixed-point format as the engine.
- MAX_ITER, 256, engine iteration limit; iteration field width is IW = $clog2(MAX_ITER).
- H_RES, 160, pixels per row.
- V_RES, 120, rows per frame.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- go  in  1  start a frame; sampled only in IDLE
- abort  in  1  abandon the current frame, return to IDLE
- x_min  in  FIXED_POINT_WIDTH  signed real part of pixel (0,0)
- y_min  in  FIXED_POINT_WIDTH  signed imaginary part of pixel (0,0)
- step  in  FIXED_POINT_WIDTH  signed per-pixel increment, both axes
- eng_start  out  1  one-cycle start pulse to the engine
- eng_c_real  out  FIXED_POINT_WIDTH  c real to the engine
- eng_c_imag  out  FIXED_POINT_WIDTH  c imaginary to the engine
- eng_valid  in  1  engine result valid (registered in the engine)
- eng_iterations  in  IW  engine iteration count
- eng_is_mandelbrot  in  1  engine in-set flag
- pix_valid  out  1  pixel result available
- pix_ready  in  1  downstream accepts the pixel
- pix_x  out  $clog2(H_RES)  pixel column
- pix_y  out  $clog2(V_RES)  pixel row
- pix_iter  out  IW  captured iteration count
- pix_in_set  out  1  captured in-set flag
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; x=y=0; coordinate registers 0.
- FSM states: IDLE, ISSUE, WAIT, EMIT, DONE.
- IDLE:
  - On go=1: latch x_min, y_min, step; set x=0, y=0, cr=x_min, ci=y_min; go to ISSUE.
  - go is ignored in every other state.
- ISSUE (exactly 1 cycle):
  - eng_start=1; eng_c_real=cr and eng_c_imag=ci, both registered and stable from ISSUE through EMIT.
  - eng_valid is ignored in this cycle, because it still reflects the previous pixel.
  - Next state: WAIT.
- WAIT:
  - On eng_valid=1: capture eng_iterations into pix_iter and eng_is_mandelbrot into pix_in_set, with pix_x=x and pix_y=y; go to EMIT.
  - Minimum ISSUE-to-EMIT latency is 3 cycles (|c|>=2 case). Maximum is about MAX_ITER+3 cycles.
- EMIT:
  - pix_valid=1. pix_x, pix_y, pix_iter and pix_in_set are held stable until pix_ready=1.
  - Transfer occurs when pix_valid && pix_ready at a rising edge.
  - On transfer, if x<H_RES-1: x+=1, cr+=step, go to ISSUE.
  - On transfer, else if y<V_RES-1: x=0, y+=1, cr=x_min(latched), ci+=step, go to ISSUE.
  - On transfer, else: go to DONE.
  - pix_valid drops in the cycle after transfer.
- DONE (1 cycle): frame_done=1; next state IDLE.
- Arithmetic:
  - cr and ci additions are FIXED_POINT_WIDTH-bit two's complement and wrap silently; no saturation.
  - cr is recomputed incrementally, never by multiplication.
- abort:
  - Highest priority in ISSUE, WAIT and EMIT: next state IDLE.
  - pix_valid deasserts the next cycle. No frame_done. The engine is left free-running.
  - An abort in the same cycle as a pix transfer: the transfer counts, then the FSM goes to IDLE.
  - abort in IDLE or DONE is ignored (DONE still pulses frame_done).
- go and abort both high in IDLE: abort wins, stay IDLE.
- Back-to-back frames: go held high through DONE starts a new frame on the first IDLE cycle, with at least 1 idle cycle between frames.
- rst asserted mid-frame: immediate return to the reset state; no partial outputs.

Test Plan:
- Basic frame, H_RES=4, V_RES=2, x_min=0xE000, y_min=0xF000, step=0x0400, pix_ready=1, engine model with fixed 5-cycle latency -> 8 pixels in raster order (0,0)..(3,1). eng_c_real sequence is E000,E400,E800,EC00, then repeats for row 1. eng_c_imag is F000 for row 0 and F400 for row 1. frame_done pulses once, 1 cycle after the last transfer.
- Backpressure: pix_ready=0 for 10 cycles on pixel (2,0) -> pix_valid and all pix fields held constant. No eng_start during the stall. Exactly one transfer occurs when pix_ready rises.
- Early-valid guard: engine's eng_valid left high from the previous pixel during the ISSUE cycle -> not captured. The captured pix_iter equals the new pixel's value.
- Wrap: x_min=0x7F00, step=0x0100, H_RES=4 -> eng_c_real sequence is 7F00, 8000, 8100, 8200, with no stall or error.
- Abort in WAIT at pixel (1,1) -> IDLE next cycle, busy=0, no frame_done. A following go restarts the frame at (0,0) with newly latched x_min.
- Async rst pulsed mid-EMIT -> all outputs 0 immediately, state IDLE. go=1 with abort=1 in IDLE -> stays IDLE.

Source files
------------

// File: rtl/mandel_frame_sequencer.sv
// -----------------------------------------------------------------------------
// mandel_frame_sequencer
//
// Walks an H_RES x V_RES pixel grid in raster order. For each pixel it drives
// one start into the shared Mandelbrot iteration engine with the pixel's complex
// constant c, waits for the engine's result, and presents that result on a
// ready/valid pixel stream toward the framebuffer / colour-gradient stage.
// This block is the only driver of the engine's start and c inputs.
//
// Ports:
//   clk, rst            system clock (rising edge), async active-high reset
//   go                  start a frame (sampled only while idle)
//   abort               abandon the current frame and return to idle
//   x_min, y_min        signed c of pixel (0,0)
//   step                signed per-pixel increment on both axes
//   eng_start           one-cycle start pulse to the engine
//   eng_c_real/imag     c presented to the engine, held from issue to emit
//   eng_valid           engine result valid
//   eng_iterations      engine iteration count
//   eng_is_mandelbrot   engine in-set flag
//   pix_valid/ready     pixel stream handshake
//   pix_x, pix_y        pixel coordinates of the presented result
//   pix_iter/pix_in_set captured engine result
//   busy                high whenever a frame is in progress (not idle)
//   frame_done          one-cycle pulse when the last pixel has been accepted
// -----------------------------------------------------------------------------
module mandel_frame_sequencer #(
  parameter int FIXED_POINT_WIDTH = 16,
  parameter int MAX_ITER          = 256,
  parameter int H_RES             = 160,
  parameter int V_RES             = 120,
  localparam int IW = $clog2(MAX_ITER),
  localparam int XW = $clog2(H_RES),
  localparam int YW = $clog2(V_RES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  input  logic                         abort,
  input  logic [FIXED_POINT_WIDTH-1:0] x_min,
  input  logic [FIXED_POINT_WIDTH-1:0] y_min,
  input  logic [FIXED_POINT_WIDTH-1:0] step,
  output logic                         eng_start,
  output logic [FIXED_POINT_WIDTH-1:0] eng_c_real,
  output logic [FIXED_POINT_WIDTH-1:0] eng_c_imag,
  input  logic                         eng_valid,
  input  logic [IW-1:0]                eng_iterations,
  input  logic                         eng_is_mandelbrot,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [XW-1:0]                pix_x,
  output logic [YW-1:0]                pix_y,
  output logic [IW-1:0]                pix_iter,
  output logic                         pix_in_set,
  output logic                         busy,
  output logic                         frame_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  logic [2:0]                   state_q,      state_d;
  logic [XW-1:0]                x_q,          x_d;
  logic [YW-1:0]                y_q,          y_d;
  logic [FIXED_POINT_WIDTH-1:0] cr_q,         cr_d;
  logic [FIXED_POINT_WIDTH-1:0] ci_q,         ci_d;
  logic [FIXED_POINT_WIDTH-1:0] x_min_q,      x_min_d;
  logic [FIXED_POINT_WIDTH-1:0] step_q,       step_d;
  logic [IW-1:0]                pix_iter_q,   pix_iter_d;
  logic                         pix_in_set_q, pix_in_set_d;

  logic transfer;

  assign transfer = (state_q == S_EMIT) && pix_ready;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cr_d         = cr_q;
    ci_d         = ci_q;
    x_min_d      = x_min_q;
    step_d       = step_q;
    pix_iter_d   = pix_iter_q;
    pix_in_set_d = pix_in_set_q;

    case (state_q)
      S_IDLE: begin
        // abort beats go when both are seen in the same idle cycle
        if (go && !abort) begin
          x_min_d = x_min;
          step_d  = step;
          x_d     = '0;
          y_d     = '0;
          cr_d    = x_min;
          ci_d    = y_min;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // eng_valid may still be high from the previous pixel here, so it is
        // deliberately not looked at until the following cycle
        state_d = abort ? S_IDLE : S_WAIT;
      end

      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (eng_valid) begin
          pix_iter_d   = eng_iterations;
          pix_in_set_d = eng_is_mandelbrot;
          state_d      = S_EMIT;
        end
      end

      S_EMIT: begin
        if (transfer) begin
          // c is stepped incrementally; the adds wrap in two's complement
          if (x_q != X_LAST) begin
            x_d     = x_q + 1'b1;
            cr_d    = cr_q + step_q;
            state_d = S_ISSUE;
          end else if (y_q != Y_LAST) begin
            x_d     = '0;
            y_d     = y_q + 1'b1;
            cr_d    = x_min_q;
            ci_d    = ci_q + step_q;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
        // an accepted pixel still counts when abort arrives with it
        if (abort) begin
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cr_q         <= '0;
      ci_q         <= '0;
      x_min_q      <= '0;
      step_q       <= '0;
      pix_iter_q   <= '0;
      pix_in_set_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cr_q         <= cr_d;
      ci_q         <= ci_d;
      x_min_q      <= x_min_d;
      step_q       <= step_d;
      pix_iter_q   <= pix_iter_d;
      pix_in_set_q <= pix_in_set_d;
    end
  end

  // every output is a register or a decode of the registered state
  assign eng_start  = (state_q == S_ISSUE);
  assign eng_c_real = cr_q;
  assign eng_c_imag = ci_q;
  assign pix_valid  = (state_q == S_EMIT);
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_iter   = pix_iter_q;
  assign pix_in_set = pix_in_set_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_mandel_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mandel_frame_sequencer
//
// Directed bench for a 4 x 2 grid. A small engine model answers each start
// after a fixed latency with a result derived from c, and keeps its valid high
// afterwards so that a stale valid is present during every issue cycle.
// -----------------------------------------------------------------------------
module tb_mandel_frame_sequencer;

  localparam int FPW = 16;
  localparam int MI  = 256;
  localparam int HR  = 4;
  localparam int VR  = 2;
  localparam int IW  = 8;
  localparam int XW  = 2;
  localparam int YW  = 1;
  localparam int LAT = 5;

  logic           clk   = 1'b0;
  logic           rst   = 1'b0;
  logic           go    = 1'b0;
  logic           abort = 1'b0;
  logic [FPW-1:0] x_min = '0;
  logic [FPW-1:0] y_min = '0;
  logic [FPW-1:0] step  = '0;
  logic           pix_ready = 1'b1;

  logic           eng_start;
  logic [FPW-1:0] eng_c_real, eng_c_imag;
  logic           eng_valid;
  logic [IW-1:0]  eng_iterations;
  logic           eng_is_mandelbrot;
  logic           pix_valid;
  logic [XW-1:0]  pix_x;
  logic [YW-1:0]  pix_y;
  logic [IW-1:0]  pix_iter;
  logic           pix_in_set;
  logic           busy, frame_done;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  int xfer_cnt  = 0;

  logic [FPW-1:0] fr_xm, fr_ym, fr_st;

  mandel_frame_sequencer #(
    .FIXED_POINT_WIDTH(FPW),
    .MAX_ITER(MI),
    .H_RES(HR),
    .V_RES(VR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .go(go),
    .abort(abort),
    .x_min(x_min),
    .y_min(y_min),
    .step(step),
    .eng_start(eng_start),
    .eng_c_real(eng_c_real),
    .eng_c_imag(eng_c_imag),
    .eng_valid(eng_valid),
    .eng_iterations(eng_iterations),
    .eng_is_mandelbrot(eng_is_mandelbrot),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_iter(pix_iter),
    .pix_in_set(pix_in_set),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] model_iter(input logic [FPW-1:0] cr, input logic [FPW-1:0] ci);
    return cr[15:8] + ci[15:8];
  endfunction

  function automatic logic model_set(input logic [FPW-1:0] cr, input logic [FPW-1:0] ci);
    return cr[10] ^ ci[10];
  endfunction

  function automatic logic [FPW-1:0] exp_c(input logic [FPW-1:0] base, input int idx, input logic [FPW-1:0] st);
    return base + FPW'(idx) * st;
  endfunction

  // engine model: fixed latency, valid stays high until the next start
  logic [3:0]     lat_cnt;
  logic [FPW-1:0] pend_cr, pend_ci;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_valid         <= 1'b0;
      eng_iterations    <= '0;
      eng_is_mandelbrot <= 1'b0;
      lat_cnt           <= '0;
      pend_cr           <= '0;
      pend_ci           <= '0;
    end else if (eng_start) begin
      eng_valid <= 1'b0;
      lat_cnt   <= 4'(LAT);
      pend_cr   <= eng_c_real;
      pend_ci   <= eng_c_imag;
    end else if (lat_cnt != 4'd0) begin
      lat_cnt <= lat_cnt - 4'd1;
      if (lat_cnt == 4'd1) begin
        eng_valid         <= 1'b1;
        eng_iterations    <= model_iter(pend_cr, pend_ci);
        eng_is_mandelbrot <= model_set(pend_cr, pend_ci);
      end
    end
  end

  // event counters sampled on the active edge
  always @(posedge clk) begin
    if (eng_start)              start_cnt <= start_cnt + 1;
    if (frame_done)             done_cnt  <= done_cnt + 1;
    if (pix_valid && pix_ready) xfer_cnt  <= xfer_cnt + 1;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [FPW-1:0] xm, input logic [FPW-1:0] ym, input logic [FPW-1:0] st);
    fr_xm = xm;
    fr_ym = ym;
    fr_st = st;
    x_min = xm;
    y_min = ym;
    step  = st;
    go    = 1'b1;
    tick();
    go    = 1'b0;
    checkOutput("go_busy", 32'(busy), 32'd1);
  endtask

  task automatic waitIssue(input logic [FPW-1:0] ecr, input logic [FPW-1:0] eci);
    for (int i = 0; i < 40 && eng_start !== 1'b1; i++) tick();
    checkOutput("issue_seen", 32'(eng_start), 32'd1);
    checkOutput("c_real", 32'(eng_c_real), 32'(ecr));
    checkOutput("c_imag", 32'(eng_c_imag), 32'(eci));
  endtask

  task automatic runPixel(input int px, input int py, input bit stall);
    logic [FPW-1:0] ecr, eci;
    logic [IW-1:0]  eit;
    logic           eset;
    int             s0, x0;
    ecr  = exp_c(fr_xm, px, fr_st);
    eci  = exp_c(fr_ym, py, fr_st);
    eit  = model_iter(ecr, eci);
    eset = model_set(ecr, eci);
    waitIssue(ecr, eci);
    tick();
    checkOutput("start_pulse_len", 32'(eng_start), 32'd0);
    if (stall) pix_ready = 1'b0;
    for (int i = 0; i < 40 && pix_valid !== 1'b1; i++) tick();
    checkOutput("pix_valid", 32'(pix_valid), 32'd1);
    checkOutput("pix_x", 32'(pix_x), 32'(px));
    checkOutput("pix_y", 32'(pix_y), 32'(py));
    checkOutput("pix_iter", 32'(pix_iter), 32'(eit));
    checkOutput("pix_in_set", 32'(pix_in_set), 32'(eset));
    if (stall) begin
      s0 = start_cnt;
      x0 = xfer_cnt;
      repeat (10) begin
        tick();
        checkOutput("stall_valid", 32'(pix_valid), 32'd1);
        checkOutput("stall_x", 32'(pix_x), 32'(px));
        checkOutput("stall_iter", 32'(pix_iter), 32'(eit));
        checkOutput("stall_c_real", 32'(eng_c_real), 32'(ecr));
      end
      checkOutput("stall_no_start", 32'(start_cnt), 32'(s0));
      checkOutput("stall_no_xfer", 32'(xfer_cnt), 32'(x0));
      pix_ready = 1'b1;
    end
    x0 = xfer_cnt;
    tick();
    checkOutput("one_xfer", 32'(xfer_cnt), 32'(x0 + 1));
    checkOutput("valid_drop", 32'(pix_valid), 32'd0);
  endtask

  task automatic finishFrame();
    int d0;
    d0 = done_cnt;
    checkOutput("frame_done", 32'(frame_done), 32'd1);
    checkOutput("done_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("done_count", 32'(done_cnt), 32'(d0 + 1));
    checkOutput("done_len", 32'(frame_done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;

    // reset state
    #1 rst = 1'b1;
    repeat (3) tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_eng_start", 32'(eng_start), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_c_real", 32'(eng_c_real), 32'd0);
    checkOutput("rst_pix_iter", 32'(pix_iter), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_no_go", 32'(busy), 32'd0);

    // basic frame with backpressure on pixel (2,0)
    $display("[TB] basic frame");
    applyStimulus(16'hE000, 16'hF000, 16'h0400);
    for (int y = 0; y < VR; y++)
      for (int x = 0; x < HR; x++)
        runPixel(x, y, (x == 2 && y == 0));
    finishFrame();

    // wrapping real axis; go held through DONE starts the next frame after one idle cycle
    $display("[TB] wrap frame");
    applyStimulus(16'h7F00, 16'h0000, 16'h0100);
    for (int y = 0; y < VR; y++)
      for (int x = 0; x < HR; x++)
        runPixel(x, y, 1'b0);
    go = 1'b1;
    finishFrame();
    tick();
    go = 1'b0;
    checkOutput("b2b_start", 32'(eng_start), 32'd1);
    checkOutput("b2b_c_real", 32'(eng_c_real), 32'h7F00);
    checkOutput("b2b_pix_x", 32'(pix_x), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_issue_busy", 32'(busy), 32'd0);
    checkOutput("abort_issue_start", 32'(eng_start), 32'd0);

    // abort while waiting at pixel (1,1)
    $display("[TB] abort frame");
    applyStimulus(16'h1000, 16'h2000, 16'h0100);
    for (int i = 0; i < HR + 1; i++) runPixel(i % HR, i / HR, 1'b0);
    waitIssue(exp_c(fr_xm, 1, fr_st), exp_c(fr_ym, 1, fr_st));
    tick();
    checkOutput("wait_busy", 32'(busy), 32'd1);
    checkOutput("wait_pix_valid", 32'(pix_valid), 32'd0);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_pix_valid", 32'(pix_valid), 32'd0);
    repeat (8) tick();
    checkOutput("abort_still_idle", 32'(busy), 32'd0);
    checkOutput("abort_no_done", 32'(done_cnt), 32'(d0));

    // restart with new origin
    $display("[TB] restart frame");
    applyStimulus(16'h3000, 16'h4000, 16'h0200);
    for (int y = 0; y < VR; y++)
      for (int x = 0; x < HR; x++)
        runPixel(x, y, 1'b0);
    finishFrame();

    // asynchronous reset while a pixel is being presented
    $display("[TB] reset mid-emit");
    applyStimulus(16'h0100, 16'h0200, 16'h0010);
    waitIssue(16'h0100, 16'h0200);
    tick();
    pix_ready = 1'b0;
    for (int i = 0; i < 40 && pix_valid !== 1'b1; i++) tick();
    checkOutput("pre_rst_valid", 32'(pix_valid), 32'd1);
    checkOutput("pre_rst_iter", 32'(pix_iter), 32'h03);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_pix_iter", 32'(pix_iter), 32'd0);
    checkOutput("async_c_real", 32'(eng_c_real), 32'd0);
    checkOutput("async_c_imag", 32'(eng_c_imag), 32'd0);
    checkOutput("async_eng_start", 32'(eng_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pix_ready = 1'b1;
    tick();

    // go and abort together while idle
    go    = 1'b1;
    abort = 1'b1;
    tick();
    checkOutput("go_abort_busy", 32'(busy), 32'd0);
    checkOutput("go_abort_start", 32'(eng_start), 32'd0);
    tick();
    checkOutput("go_abort_busy2", 32'(busy), 32'd0);
    go    = 1'b0;
    abort = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
